inst_fetch: RTL and testbench
=============================

Name: inst_fetch

Overview:
- Instruction fetch stage that sits directly upstream of the instruction decoder/controller.
- Holds the program counter and issues word reads to instruction memory.
- Buffers returned 32-bit instructions in a small FIFO and presents them to the decoder with a valid/ready handshake.
- Supports PC redirect (jump/branch) with flush, and a halt input that stops fetching.

Parameters:
- PC_W, 32, width of the PC and the instruction memory address.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- BUF_DEPTH, 2, instruction buffer entries (power of 2, at least 2).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- imem_req  out  1  read request, valid for one cycle per request.
- imem_addr  out  PC_W  byte address of the request; equals the PC at issue.
- imem_rvalid  in  1  read data valid; responses return in order, latency of at least 1 cycle.
- imem_rdata  in  32  instruction word.
- redirect_valid  in  1  load a new PC and flush.
- redirect_pc  in  PC_W  target PC; bits [1:0] are ignored and forced to 0.
- halt  in  1  while high, no new requests are issued.
- inst  out  32  instruction at the buffer head, to the decoder.
- inst_pc  out  PC_W  PC of inst.
- inst_valid  out  1  buffer non-empty.
- inst_ready  in  1  decoder accepts; a pop occurs when inst_valid && inst_ready.

Behaviour:
- Reset (synchronous, active-high): on the rising clk edge with rst=1:
  - pc=RESET_PC, buffer empty, state=FETCH.
  - imem_req=0, imem_addr=RESET_PC.
  - inst_valid=0, inst=0, inst_pc=0.
- Reset mid-operation: any outstanding response arriving after reset is discarded. Reset forces state DROP if a request was outstanding at reset; the block tracks this with a single outstanding flag.
- At most one request is outstanding at any time.
- FSM states:
  - FETCH: no request outstanding. Issue when !halt && !redirect_valid && (count + 0) < BUF_DEPTH. On issue: imem_req=1, imem_addr=pc, pc<=pc+4, go to WAIT. Otherwise stay in FETCH.
  - WAIT: one request outstanding. On imem_rvalid, push {imem_rdata, issued_pc} and go to FETCH. Back-to-back issue in the same cycle is not allowed, so the best case is one instruction every 2 cycles.
  - DROP: outstanding response must be discarded. On imem_rvalid, drop the data and go to FETCH.
- Redirect (highest priority after rst):
  - pc<=redirect_pc with [1:0] zeroed; buffer flushed (count=0, inst_valid=0 next cycle).
  - In WAIT, or if imem_rvalid arrives in the same cycle as the redirect: that data is dropped. WAIT goes to DROP; if rvalid is in the same cycle, go to FETCH instead.
  - No request is issued in the redirect cycle.
  - A pop in the redirect cycle is permitted; the decoder accepts that instruction.
- Buffer:
  - Circular FIFO with wrapping read/write pointers and a count of 0..BUF_DEPTH.
  - Simultaneous push and pop: count unchanged. Pop on empty is ignored.
  - Push when full is impossible by construction: issue requires count < BUF_DEPTH. Keep an assertion for it.
- Output timing:
  - inst/inst_pc are driven from the buffer head (registered storage, combinational read).
  - inst_valid = (count != 0).
  - A pushed instruction is visible the cycle after imem_rvalid.
- halt:
  - Blocks new issues only. An outstanding response still completes and is pushed.
  - Buffered instructions still drain.
- PC arithmetic: modulo 2^PC_W; wrap-around from all-ones-minus-3 to 0 is legal.

Optional Feature:
- Macro: INST_FETCH_PERF_EN.
- Defined: adds outputs perf_fetched (32-bit) and perf_stall (32-bit), both reset to 0.
  - perf_fetched increments on every push.
  - perf_stall increments each cycle inst_valid=0 && !halt.
  - Both wrap at 2^32.
- Undefined: neither port nor counter exists; behaviour is otherwise identical.

Test Plan:
- Reset then run with memory latency 1, inst_ready=1, RESET_PC=0:
  - imem_addr sequence is 0x0, 0x4, 0x8, with a request every 2 cycles.
  - inst_pc follows 0x0, 0x4, 0x8 with matching rdata.
- inst_ready=0 held:
  - After 2 pushes, inst_valid=1 and no further imem_req.
  - Raising inst_ready drains in order, then fetch resumes at 0x8.
- Redirect to 0x103 while a request is outstanding (latency 3):
  - The response for the old PC is dropped; the buffer is empty the next cycle.
  - The next imem_addr=0x100; first inst_pc=0x100.
- Redirect asserted in the same cycle as imem_rvalid:
  - Data is not pushed; the state returns to FETCH.
  - The next request is at the target PC.
- halt=1 for 10 cycles mid-stream:
  - No imem_req is issued; the pending response is pushed and the buffer drains.
  - On halt=0, fetch continues from the next sequential PC.
- rst pulsed while WAIT, response arriving 2 cycles later:
  - The response is discarded; inst_valid stays 0 until a fresh fetch from RESET_PC returns.

Source files
------------

// File: rtl/inst_fetch_if.sv
// Fetch-stage bus: instruction-memory read port, redirect/halt controls and
// the valid/ready instruction stream toward the decoder.
interface inst_fetch_if #(
  parameter int PC_W = 32
) ();
  logic            imem_req;
  logic [PC_W-1:0] imem_addr;
  logic            imem_rvalid;
  logic [31:0]     imem_rdata;
  logic            redirect_valid;
  logic [PC_W-1:0] redirect_pc;
  logic            halt;
  logic [31:0]     inst;
  logic [PC_W-1:0] inst_pc;
  logic            inst_valid;
  logic            inst_ready;

  modport master (
    output imem_req, imem_addr, inst, inst_pc, inst_valid,
    input  imem_rvalid, imem_rdata, redirect_valid, redirect_pc, halt, inst_ready
  );

  modport slave (
    input  imem_req, imem_addr, inst, inst_pc, inst_valid,
    output imem_rvalid, imem_rdata, redirect_valid, redirect_pc, halt, inst_ready
  );
endinterface

// File: rtl/inst_fetch.sv
// Instruction fetch stage: PC, single-outstanding imem reads, small instruction FIFO.
// Optional performance counters are enabled with the INST_FETCH_PERF_EN macro.
module inst_fetch #(
  parameter int              PC_W      = 32,
  parameter logic [PC_W-1:0] RESET_PC  = '0,
  parameter int              BUF_DEPTH = 2
) (
  input  logic clk,
  input  logic rst,
`ifdef INST_FETCH_PERF_EN
  inst_fetch_if.master bus,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_stall
`else
  inst_fetch_if.master bus
`endif
);

  localparam int PTR_W = $clog2(BUF_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_WAIT  = 2'd1,
    S_DROP  = 2'd2
  } state_t;

  state_t           r_state;
  logic [PC_W-1:0]  r_pc;
  logic [PC_W-1:0]  r_issued_pc;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [CNT_W-1:0] r_count;
  logic [31:0]      r_buf_inst [BUF_DEPTH];
  logic [PC_W-1:0]  r_buf_pc   [BUF_DEPTH];

  logic            w_issue;
  logic            w_push;
  logic            w_pop;
  logic            w_valid;
  logic [PC_W-1:0] w_redirect_pc;

  // The request is decoded from the current state rather than registered so a
  // response arriving one cycle later lets the next request go out right after.
  assign w_issue = !rst && (r_state == S_FETCH) && !bus.halt && !bus.redirect_valid
                   && (r_count < CNT_W'(BUF_DEPTH));
  assign w_push  = (r_state == S_WAIT) && bus.imem_rvalid && !bus.redirect_valid;
  assign w_valid = (r_count != '0);
  assign w_pop   = w_valid && bus.inst_ready;
  assign w_redirect_pc = bus.redirect_pc & ~PC_W'(3);

  assign bus.imem_req   = w_issue;
  assign bus.imem_addr  = r_pc;
  assign bus.inst_valid = w_valid;
  assign bus.inst       = w_valid ? r_buf_inst[r_rd_ptr] : '0;
  assign bus.inst_pc    = w_valid ? r_buf_pc[r_rd_ptr]   : '0;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      // A response still in flight must be swallowed once it shows up.
      if ((r_state != S_FETCH) && !bus.imem_rvalid) r_state <= S_DROP;
      else                                          r_state <= S_FETCH;
      r_pc        <= RESET_PC;
      r_issued_pc <= RESET_PC;
      r_rd_ptr    <= '0;
      r_wr_ptr    <= '0;
      r_count     <= '0;
    end else begin
      case (r_state)
        S_FETCH: begin
          if (w_issue) begin
            r_state     <= S_WAIT;
            r_issued_pc <= r_pc;
            r_pc        <= r_pc + PC_W'(4);
          end
        end
        S_WAIT: begin
          if (bus.imem_rvalid)         r_state <= S_FETCH;
          else if (bus.redirect_valid) r_state <= S_DROP;
        end
        S_DROP: begin
          if (bus.imem_rvalid) r_state <= S_FETCH;
        end
        default: r_state <= S_FETCH;
      endcase

      if (bus.redirect_valid) begin
        r_pc     <= w_redirect_pc;
        r_rd_ptr <= '0;
        r_wr_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
        if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + CNT_W'(1);
          2'b01:   r_count <= r_count - CNT_W'(1);
          default: r_count <= r_count;
        endcase
      end
    end
  end

  // NOTE: buffer storage has no reset; reads are masked while the count is zero.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_buf_inst[r_wr_ptr] <= bus.imem_rdata;
      r_buf_pc[r_wr_ptr]   <= r_issued_pc;
    end
  end

`ifdef INST_FETCH_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetched <= '0;
      perf_stall   <= '0;
    end else begin
      if (w_push)                perf_fetched <= perf_fetched + 32'd1;
      if (!w_valid && !bus.halt) perf_stall   <= perf_stall + 32'd1;
    end
  end
`endif

  a_no_push_when_full: assert property (@(posedge clk) disable iff (rst)
    !(w_push && (r_count == CNT_W'(BUF_DEPTH))));

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: table-driven streaming vectors plus hand-written
// sequences for redirect, halt and reset-with-outstanding-request corner cases.
module tb_inst_fetch;
  localparam int PC_W = 32;

  logic clk = 1'b0;
  logic rst;

  inst_fetch_if #(.PC_W(PC_W)) bus ();

`ifdef INST_FETCH_PERF_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_stall;
  inst_fetch #(.PC_W(PC_W), .RESET_PC('0), .BUF_DEPTH(2)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .perf_fetched(perf_fetched), .perf_stall(perf_stall)
  );
`else
  inst_fetch #(.PC_W(PC_W), .RESET_PC('0), .BUF_DEPTH(2)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
`endif

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Memory model: one pending read, response `mem_lat` cycles after the request.
  int          mem_lat = 1;
  bit          pend = 1'b0;
  int          rem = 0;
  logic [31:0] pend_addr = '0;

  typedef struct {
    bit          pre_rst;
    bit          ready;
    bit          e_req;
    logic [31:0] e_addr;
    bit          e_valid;
    logic [31:0] e_pc;
  } vec_t;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'hC0DE_0000 ^ a;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    logic        req_s;
    logic [31:0] addr_s;
    #1;
    req_s  = bus.imem_req;
    addr_s = bus.imem_addr;
    @(posedge clk);
    #1;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = '0;
    if (req_s === 1'b1) begin
      check("single_outstanding", {31'b0, pend}, 32'd0);
      pend      = 1'b1;
      rem       = mem_lat - 1;
      pend_addr = addr_s;
    end else if (pend) begin
      rem--;
    end
    if (pend && rem == 0) begin
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata  = mem_word(pend_addr);
      pend            = 1'b0;
    end
  endtask

  task automatic do_reset();
    rst                = 1'b1;
    bus.halt           = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    repeat (3) step();
    check("rst_req",     {31'b0, bus.imem_req},   32'd0);
    check("rst_addr",    bus.imem_addr,           32'h0);
    check("rst_valid",   {31'b0, bus.inst_valid}, 32'd0);
    check("rst_inst",    bus.inst,                32'h0);
    check("rst_inst_pc", bus.inst_pc,             32'h0);
    rst = 1'b0;
  endtask

  task automatic wait_valid(input string name, input int budget);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (bus.inst_valid) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    check({name, "_timeout"}, {31'b0, ok}, 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t vecs[16];
    int   pops;
    logic [31:0] pop_pc;
    bit   seen_valid;

    vecs = '{
      // streaming, latency 1, decoder always ready
      '{0, 1, 1, 32'h0, 0, 32'h0},
      '{0, 1, 0, 32'h4, 0, 32'h0},
      '{0, 1, 1, 32'h4, 1, 32'h0},
      '{0, 1, 0, 32'h8, 0, 32'h0},
      '{0, 1, 1, 32'h8, 1, 32'h4},
      '{0, 1, 0, 32'hC, 0, 32'h0},
      '{0, 1, 1, 32'hC, 1, 32'h8},
      // decoder stalled until the buffer fills, then drains
      '{1, 0, 1, 32'h0, 0, 32'h0},
      '{0, 0, 0, 32'h4, 0, 32'h0},
      '{0, 0, 1, 32'h4, 1, 32'h0},
      '{0, 0, 0, 32'h8, 1, 32'h0},
      '{0, 0, 0, 32'h8, 1, 32'h0},
      '{0, 1, 0, 32'h8, 1, 32'h0},
      '{0, 1, 1, 32'h8, 1, 32'h4},
      '{0, 1, 0, 32'hC, 0, 32'h0},
      '{0, 1, 1, 32'hC, 1, 32'h8}
    };

    bus.imem_rvalid    = 1'b0;
    bus.imem_rdata     = '0;
    bus.inst_ready     = 1'b1;
    bus.halt           = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    rst                = 1'b1;
    do_reset();

    mem_lat = 1;
    foreach (vecs[i]) begin
      if (vecs[i].pre_rst) do_reset();
      bus.inst_ready = vecs[i].ready;
      #1;
      check($sformatf("vec%0d_req", i),   {31'b0, bus.imem_req},   {31'b0, vecs[i].e_req});
      check($sformatf("vec%0d_addr", i),  bus.imem_addr,           vecs[i].e_addr);
      check($sformatf("vec%0d_valid", i), {31'b0, bus.inst_valid}, {31'b0, vecs[i].e_valid});
      check($sformatf("vec%0d_pc", i),    bus.inst_pc,             vecs[i].e_pc);
      check($sformatf("vec%0d_inst", i),  bus.inst,
            vecs[i].e_valid ? mem_word(vecs[i].e_pc) : 32'h0);
      step();
    end

    // Redirect to 0x103 while a latency-3 read is outstanding.
    do_reset();
    mem_lat = 3;
    bus.inst_ready = 1'b1;
    #1;
    check("rdw_issue_req",  {31'b0, bus.imem_req}, 32'd1);
    check("rdw_issue_addr", bus.imem_addr,         32'h0);
    step();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h103;
    #1;
    check("rdw_no_req_in_redirect", {31'b0, bus.imem_req}, 32'd0);
    step();
    bus.redirect_valid = 1'b0;
    #1;
    check("rdw_flushed_valid", {31'b0, bus.inst_valid}, 32'd0);
    check("rdw_new_pc",        bus.imem_addr,           32'h100);
    check("rdw_drop_no_req",   {31'b0, bus.imem_req},   32'd0);
    step();
    #1;
    check("rdw_drop_no_req2", {31'b0, bus.imem_req}, 32'd0);
    step();
    #1;
    check("rdw_old_data_dropped", {31'b0, bus.inst_valid}, 32'd0);
    check("rdw_refetch_req",      {31'b0, bus.imem_req},   32'd1);
    check("rdw_refetch_addr",     bus.imem_addr,           32'h100);
    step();
    wait_valid("rdw_first", 8);
    check("rdw_first_pc",   bus.inst_pc, 32'h100);
    check("rdw_first_inst", bus.inst,    mem_word(32'h100));

    // Redirect in the same cycle as the response.
    do_reset();
    mem_lat = 1;
    #1;
    check("rdv_issue_req", {31'b0, bus.imem_req}, 32'd1);
    step();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h202;
    #1;
    check("rdv_rvalid_now", {31'b0, bus.imem_rvalid}, 32'd1);
    check("rdv_no_req",     {31'b0, bus.imem_req},    32'd0);
    step();
    bus.redirect_valid = 1'b0;
    #1;
    check("rdv_not_pushed", {31'b0, bus.inst_valid}, 32'd0);
    check("rdv_fetch_req",  {31'b0, bus.imem_req},   32'd1);
    check("rdv_fetch_addr", bus.imem_addr,           32'h200);
    step();
    wait_valid("rdv_first", 8);
    check("rdv_first_pc",   bus.inst_pc, 32'h200);
    check("rdv_first_inst", bus.inst,    mem_word(32'h200));

    // Halt for 10 cycles with one read in flight.
    do_reset();
    mem_lat = 2;
    bus.inst_ready = 1'b1;
    #1;
    check("halt_pre_addr", bus.imem_addr, 32'h0);
    step();
    pops = 0;
    pop_pc = '1;
    for (int i = 0; i < 10; i++) begin
      bus.halt = 1'b1;
      #1;
      check($sformatf("halt_no_req%0d", i), {31'b0, bus.imem_req}, 32'd0);
      if (bus.inst_valid) begin
        pops++;
        pop_pc = bus.inst_pc;
      end
      step();
    end
    check("halt_pushed_count", pops,   32'd1);
    check("halt_pushed_pc",    pop_pc, 32'h0);
    check("halt_drained",      {31'b0, bus.inst_valid}, 32'd0);
    bus.halt = 1'b0;
    #1;
    check("halt_resume_req",  {31'b0, bus.imem_req}, 32'd1);
    check("halt_resume_addr", bus.imem_addr,         32'h4);
    step();

    // Reset while a read is outstanding; the late response must be discarded.
    do_reset();
    mem_lat = 3;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h40;
    step();
    bus.redirect_valid = 1'b0;
    #1;
    check("rstw_issue_addr", bus.imem_addr, 32'h40);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    check("rstw_drop_no_req", {31'b0, bus.imem_req},   32'd0);
    check("rstw_valid0",      {31'b0, bus.inst_valid}, 32'd0);
    step();
    #1;
    check("rstw_late_rvalid", {31'b0, bus.imem_rvalid}, 32'd1);
    check("rstw_valid1",      {31'b0, bus.inst_valid},  32'd0);
    step();
    #1;
    check("rstw_fresh_req",  {31'b0, bus.imem_req},   32'd1);
    check("rstw_fresh_addr", bus.imem_addr,           32'h0);
    check("rstw_valid2",     {31'b0, bus.inst_valid}, 32'd0);
    step();
    seen_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      if (bus.inst_valid) seen_valid = 1'b1;
      step();
    end
    check("rstw_no_early_valid", {31'b0, seen_valid}, 32'd0);
    wait_valid("rstw_first", 8);
    check("rstw_first_pc",   bus.inst_pc, 32'h0);
    check("rstw_first_inst", bus.inst,    mem_word(32'h0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
